// File: rtl/cnn_feeder_pkg.sv
// Shared definitions for the CNN frame feeder: FSM state encoding and the
// frame geometry constants used by both the RTL and the testbench.
package cnn_feeder_pkg;

    localparam int FRAME_PIXELS = 784;  // 28x28 image
    localparam int IDX_BITS     = 10;   // enough to address FRAME_PIXELS

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        STREAM   = 2'd1,
        WAIT_RES = 2'd2
    } state_t;

endpackage

// File: rtl/feeder_frame_ram.sv
// Frame buffer for the CNN feeder: simple dual-port synchronous RAM.
// Ports:
//   clk              clock
//   wr_en/wr_addr/wr_data  write port (one pixel per clock)
//   rd_en/rd_addr    read request; data appears on rd_data the next cycle
//   rd_clr           synchronous clear of the read register (takes priority)
//   rd_data          registered read data
module feeder_frame_ram #(
    parameter int DEPTH = 784,
    parameter int WIDTH = 8,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             rd_clr,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // The clear lets the consumer see zero data whenever nothing is streaming.
    always_ff @(posedge clk) begin
        if (rd_clr)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/cnn_frame_feeder.sv
// CNN frame feeder: buffers one 28x28 image received over a valid/ready byte
// stream, replays it gaplessly (one pixel per clock) to conv1_layer, waits for
// the comparator's decision and returns it before accepting the next frame.
// Optional feature macro: CNN_FEEDER_TIMEOUT_EN (result watchdog; on expiry
// dec_out=all ones with dec_valid and frame_err pulsing together).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last   pixel input stream
//   m_valid/m_data        pixel output to conv1_layer (no backpressure)
//   res_valid/res_decision comparator result input
//   dec_valid/dec_out     decision pulse and held decision
//   busy                  high while streaming or waiting for the result
//   frame_err             pulse on framing error or watchdog expiry
module cnn_frame_feeder #(
    parameter int PIX_BITS       = 8,
    parameter int FRAME_PIXELS   = cnn_feeder_pkg::FRAME_PIXELS,
    parameter int IDX_BITS       = cnn_feeder_pkg::IDX_BITS,
    parameter int CLS_BITS       = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [PIX_BITS-1:0] s_data,
    input  logic                s_last,
    output logic                m_valid,
    output logic [PIX_BITS-1:0] m_data,
    input  logic                res_valid,
    input  logic [CLS_BITS-1:0] res_decision,
    output logic                dec_valid,
    output logic [CLS_BITS-1:0] dec_out,
    output logic                busy,
    output logic                frame_err
);
    import cnn_feeder_pkg::*;

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(FRAME_PIXELS - 1);

    state_t              state, state_nxt;
    logic [IDX_BITS-1:0] wr_idx, rd_idx;
    logic                xfer, load_done, load_err, res_take, timeout;

    assign xfer = (state == LOAD) && s_valid && s_ready;
    assign busy = (state != LOAD);

`ifdef CNN_FEEDER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // Held at zero outside WAIT_RES, so every entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (!rst_n || state != WAIT_RES) to_cnt <= '0;
        else                             to_cnt <= to_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_done = 1'b0;
        load_err  = 1'b0;
        res_take  = 1'b0;
        timeout   = 1'b0;
        case (state)
            LOAD: begin
                if (xfer) begin
                    if (wr_idx == LAST_IDX && s_last) begin
                        load_done = 1'b1;
                        state_nxt = STREAM;
                    end else if (wr_idx == LAST_IDX || s_last) begin
                        // Early or missing s_last: drop the frame, restart.
                        load_err = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (rd_idx == LAST_IDX) state_nxt = WAIT_RES;
            end
            WAIT_RES: begin
                if (res_valid) begin
                    res_take  = 1'b1;
                    state_nxt = LOAD;
                end
`ifdef CNN_FEEDER_TIMEOUT_EN
                else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = LOAD;
                end
`endif
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_idx    <= '0;
            rd_idx    <= '0;
            s_ready   <= 1'b0;
            m_valid   <= 1'b0;
            dec_valid <= 1'b0;
            dec_out   <= '0;
            frame_err <= 1'b0;
        end else begin
            // Registered ready: follows the state we are about to be in.
            s_ready   <= (state_nxt == LOAD);
            // Matches the one-cycle RAM read latency.
            m_valid   <= (state == STREAM);
            dec_valid <= res_take | timeout;
            frame_err <= load_err | timeout;
            if (res_take)     dec_out <= res_decision;
            else if (timeout) dec_out <= '1;
            if (xfer)
                wr_idx <= (load_done || load_err) ? '0 : wr_idx + 1'b1;
            if (state == STREAM)
                rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
        end
    end

    feeder_frame_ram #(
        .DEPTH (FRAME_PIXELS),
        .WIDTH (PIX_BITS),
        .AW    (IDX_BITS)
    ) u_ram (
        .clk     (clk),
        .wr_en   (xfer),
        .wr_addr (wr_idx),
        .wr_data (s_data),
        .rd_en   (state == STREAM),
        .rd_clr  (!rst_n || state != STREAM),
        .rd_addr (rd_idx),
        .rd_data (m_data)
    );

endmodule

// File: doc/cnn_frame_feeder.md
Name: cnn_frame_feeder

Overview:
- Receive side of the pixel stream that drives conv1_layer.
- Accepts one 28x28 image over a valid/ready byte interface and buffers it.
- Replays the image to the CNN as one pixel per clock, with no gaps.
- Waits for the comparator's decision, returns it to the requester, then accepts the next frame.

Parameters:
- PIX_BITS, 8, pixel width.
- FRAME_PIXELS, 784, pixels per frame.
- IDX_BITS, 10, pixel index width.
- CLS_BITS, 4, decision width.
- TIMEOUT_CYCLES, 65535, result watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  feeder can accept a pixel.
- s_data  in  PIX_BITS  input pixel.
- s_last  in  1  marks the final pixel of a frame.
- m_valid  out  1  m_data is a live pixel for conv1_layer.
- m_data  out  PIX_BITS  pixel to conv1_layer data_in.
- res_valid  in  1  comparator valid_out.
- res_decision  in  CLS_BITS  comparator decision.
- dec_valid  out  1  one-cycle pulse: decision available.
- dec_out  out  CLS_BITS  captured decision.
- busy  out  1  high in STREAM and WAIT_RES.
- frame_err  out  1  one-cycle pulse on a framing error or timeout.

Behaviour:
- Reset is synchronous on rst_n=0. Reset values: state=LOAD, wr_idx=0, rd_idx=0, s_ready=0, m_valid=0, m_data=0, dec_valid=0, dec_out=0, busy=0, frame_err=0.
- s_ready rises the first cycle after reset is released.
- Reset asserted mid-frame discards the buffer contents and the partial frame.
- LOAD state:
  - s_ready=1.
  - Transfer occurs when s_valid && s_ready; pixel is written to buf[wr_idx] and wr_idx increments.
  - On the transfer with wr_idx==FRAME_PIXELS-1 and s_last=1: go to STREAM, set s_ready=0 the next cycle, reset wr_idx to 0.
  - s_last=1 with wr_idx<FRAME_PIXELS-1 (early), or s_last=0 at wr_idx==FRAME_PIXELS-1 (missing): frame_err pulses, wr_idx=0, frame is dropped, state stays LOAD.
- STREAM state:
  - Buffer read is synchronous; m_data/m_valid are registered.
  - First m_valid appears 1 cycle after entering STREAM.
  - Exactly FRAME_PIXELS consecutive cycles with m_valid=1, m_data=buf[0..783] in order; no stalls, since the CNN has no backpressure.
  - After the last pixel: m_valid=0, m_data held at 0, go to WAIT_RES.
- WAIT_RES state:
  - On res_valid=1: dec_out<=res_decision, dec_valid pulses 1 cycle, go to LOAD.
  - dec_out holds its value until the next capture.
- res_valid outside WAIT_RES is ignored.
- res_decision values above 9 pass through unmodified.
- s_valid outside LOAD is not accepted (s_ready=0); the upstream holds the data.
- busy=1 in STREAM and WAIT_RES.
- Index counters never exceed FRAME_PIXELS-1; no wrap-around is possible.

Optional Feature:
- Macro: CNN_FEEDER_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT_RES. If it reaches TIMEOUT_CYCLES with no res_valid:
  - dec_out<=all ones, dec_valid pulses, frame_err pulses in the same cycle, go to LOAD.
  - Counter clears on every entry to WAIT_RES.
- Undefined: WAIT_RES waits indefinitely and no counter is synthesised.

Decomposition:
- Package cnn_feeder_pkg holds the state enum (LOAD, STREAM, WAIT_RES) and the FRAME_PIXELS/IDX_BITS constants shared with the bench.
- One sub-module, feeder_frame_ram: simple dual-port synchronous RAM, FRAME_PIXELS x PIX_BITS, one write port and one registered read port.

Test Plan:
- Frame of 784 pixels, pixel i = i mod 256, s_last on #783, then res_valid with decision 7 -> m_valid high 784 consecutive cycles with m_data matching in order; dec_out=7 with dec_valid pulsing once.
- s_valid toggled randomly 50% during LOAD -> buffer content is identical; replay is still gapless for 784 cycles.
- s_last on pixel #100 -> frame_err pulses once; next full 784-pixel frame streams correctly.
- No s_last on pixel #783 -> frame_err pulses once, state stays LOAD, no m_valid.
- res_valid pulsed during STREAM -> ignored, dec_valid stays 0; a later res_valid with decision 3 gives dec_out=3.
- rst_n low for 1 cycle at pixel #400 of STREAM -> m_valid=0 next cycle, s_ready=1 the cycle after, dec_out=0. With CNN_FEEDER_TIMEOUT_EN and TIMEOUT_CYCLES=100, no response -> dec_out=4'hF and frame_err pulse 100 cycles after entering WAIT_RES.
